mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 181 ++++++++++++++++++
 tb/tb_mc_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle MIPS-style control unit: one FSM steps each instruction through its phases,
// and a combinational decode of the registered state drives the datapath controls.
module mc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNe,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  state,
    output logic        halt,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    state_t      r_state;
    logic [5:0]  r_opcode;
    logic        r_halt;
    logic        r_illegal;
    logic [31:0] r_instr_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_opcode      <= 6'h00;
            r_halt        <= 1'b0;
            r_illegal     <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state       <= S_DECODE;
                        r_instr_count <= r_instr_count + 32'd1;
                    end
                end
                // The instruction register is only guaranteed stable here, so latch the opcode.
                S_DECODE: begin
                    r_opcode <= opcode;
                    case (opcode)
                        OP_LW, OP_SW:   r_state <= S_MEMADR;
                        OP_RTYPE: begin
                            if (funct == FN_SYSCALL) begin
                                r_state <= S_HALT;
                                r_halt  <= 1'b1;
                            end else begin
                                r_state <= S_EXEC;
                            end
                        end
                        OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                        OP_J:           r_state <= S_JUMP;
                        OP_ADDI:        r_state <= S_ADDI_EX;
                        default: begin
                            r_state   <= S_HALT;
                            r_halt    <= 1'b1;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:  r_state <= (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
                S_EXEC:    r_state <= S_RWB;
                S_ADDI_EX: r_state <= S_ADDI_WB;
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (r_opcode == OP_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state;
    assign halt        = r_halt;
    assign illegal     = r_illegal;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: an instruction-level model expands each instruction into its
// expected per-cycle states/controls; a negedge monitor pops and compares them against the DUT.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemToReg;
    logic        IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  state;
    logic        halt, illegal;
    logic [31:0] instr_count;

    mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .state(state), .halt(halt), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic        h;
        logic        il;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_halt = 1'b0;
    logic        exp_ill = 1'b0;

    wire [16:0] dut_ctrl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemToReg,
                            IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Control word per state straight from the state table, in dut_ctrl bit order.
    function automatic logic [16:0] ctl(input int st, input logic mr, input logic [5:0] lop);
        logic pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rd, asa;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rd, asa} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (lop == 6'h05); end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rd, asa, pcs, aop, asb};
    endfunction

    // One clock cycle: drive inputs, record what the DUT must show during it, advance.
    task automatic step(input int st, input logic mr, input logic [5:0] lop,
                        input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        mem_ready = mr;
        opcode    = op;
        funct     = fn;
        e.st = 4'(st); e.ctrl = ctl(st, mr, lop); e.h = exp_halt; e.il = exp_ill; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input int st, input logic mr, input logic [5:0] lop);
        step(st, mr, lop, 6'($urandom), 6'($urandom));
    endtask

    // Expand one instruction into its phase sequence; stalls are extra not-ready memory cycles.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fst,
                            input int mst, input int halt_cycles);
        for (int i = 0; i <= fst; i++) noise(0, (i == fst), 6'h00);
        exp_cnt = exp_cnt + 32'd1;
        step(1, 1'($urandom), 6'h00, op, fn);
        if (op == 6'h23) begin
            noise(2, 1'($urandom), op);
            for (int i = 0; i <= mst; i++) noise(3, (i == mst), op);
            noise(4, 1'($urandom), op);
        end else if (op == 6'h2b) begin
            noise(2, 1'($urandom), op);
            for (int i = 0; i <= mst; i++) noise(5, (i == mst), op);
        end else if (op == 6'h00 && fn != 6'h0C) begin
            noise(6, 1'($urandom), op);
            noise(7, 1'($urandom), op);
        end else if (op == 6'h04 || op == 6'h05) begin
            noise(8, 1'($urandom), op);
        end else if (op == 6'h02) begin
            noise(9, 1'($urandom), op);
        end else if (op == 6'h08) begin
            noise(10, 1'($urandom), op);
            noise(11, 1'($urandom), op);
        end else begin
            exp_halt = 1'b1;
            if (op != 6'h00) exp_ill = 1'b1;
            for (int i = 0; i < halt_cycles; i++) noise(12, 1'($urandom), op);
        end
    endtask

    task automatic clear_model();
        exp_cnt = 32'd0; exp_halt = 1'b0; exp_ill = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("ctrl", 32'(dut_ctrl), 32'(e.ctrl));
            chk("halt", 32'(halt), 32'(e.h));
            chk("illegal", 32'(illegal), 32'(e.il));
            chk("instr_count", instr_count, e.cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal [7];
        logic [5:0] op, fn;
        legal[0] = 6'h23; legal[1] = 6'h2b; legal[2] = 6'h00; legal[3] = 6'h04;
        legal[4] = 6'h05; legal[5] = 6'h02; legal[6] = 6'h08;

        // Held in reset: outputs follow the FETCH decode and no fetch completes.
        @(posedge clk); #1;
        noise(0, 1'b0, 6'h00);
        noise(0, 1'b1, 6'h00);
        reset = 1'b0;

        do_instr(6'h23, 6'h00, 0, 0, 0);
        do_instr(6'h2b, 6'h00, 0, 3, 0);
        do_instr(6'h05, 6'h00, 0, 0, 0);
        do_instr(6'h04, 6'h00, 1, 0, 0);
        do_instr(6'h02, 6'h00, 0, 0, 0);
        do_instr(6'h00, 6'h20, 2, 0, 0);
        do_instr(6'h08, 6'h00, 0, 0, 0);
        do_instr(6'h23, 6'h00, 2, 3, 0);

        for (int n = 0; n < 40; n++) begin
            op = legal[$urandom_range(0, 6)];
            fn = 6'($urandom);
            if (fn == 6'h0C) fn = 6'h20;
            do_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        // Counter wrap: two fetches from 0xFFFFFFFE.
        force dut.r_instr_count = 32'hFFFF_FFFE;
        release dut.r_instr_count;
        exp_cnt = 32'hFFFF_FFFE;
        do_instr(6'h02, 6'h00, 0, 0, 0);
        do_instr(6'h04, 6'h00, 1, 0, 0);

        // Reset aborting a stalled store: MemWrite must drop at once.
        do_instr(6'h00, 6'h00, 0, 0, 0);
        noise(0, 1'b1, 6'h00);
        exp_cnt = exp_cnt + 32'd1;
        step(1, 1'b0, 6'h00, 6'h2b, 6'h00);
        noise(2, 1'b0, 6'h2b);
        noise(5, 1'b0, 6'h2b);
        reset = 1'b1;
        clear_model();
        noise(0, 1'b1, 6'h00);
        reset = 1'b0;

        // Syscall halts (not illegal) and stays put with a frozen count.
        do_instr(6'h00, 6'h0C, 0, 0, 11);

        // Async reset pulse between edges clears halt before the next posedge.
        reset = 1'b1; #2; reset = 1'b0;
        clear_model();
        noise(0, 1'b0, 6'h00);

        do_instr(6'h3F, 6'h00, 0, 0, 4);
        reset = 1'b1; #2; reset = 1'b0;
        clear_model();
        noise(0, 1'b0, 6'h00);
        do_instr(6'h23, 6'h00, 0, 1, 0);

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
